ethernet_receiver: RTL and testbench

Receive-side counterpart of the TX path. Accepts frames from the MAC on an AXI-Stream slave port and stores them in a 2-slot packet buffer. Each completed frame is exposed to the host through a packet_* random-access read interface; the host frees a slot with an ack. Never backpressures the MAC: frames that cannot be stored are dropped whole.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/ethernet_receiver_if.sv | 16 +
 rtl/eth_rx_slot_ctrl.sv | 51 +++++
 rtl/ethernet_receiver.sv | 193 +++++++++++++++++++
 tb/tb_ethernet_receiver.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and width helpers for the Ethernet RX path.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  // Byte-count width: must represent a full slot (0..mtu inclusive).
  function automatic int eth_size_width(input int mtu);
    return $clog2(mtu + 1);
  endfunction

  function automatic int eth_addr_width(input int mtu);
    return $clog2(mtu);
  endfunction

  function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
    return n;
  endfunction

endpackage

// File: rtl/ethernet_receiver_if.sv
// AXI-Stream beat channel from the MAC into the receiver.
// A beat transfers on a rising clock edge where tvalid && tready are both high;
// tuser is meaningful only on the tlast beat, and tkeep is all ones except on tlast.
interface ethernet_receiver_if #(
  parameter int data_width_p = 32
);
  logic [data_width_p-1:0]   tdata;
  logic [data_width_p/8-1:0] tkeep;
  logic                      tvalid;
  logic                      tlast;
  logic                      tuser;
  logic                      tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_slot_ctrl.sv
// Slot bookkeeping for the RX packet buffer: head/tail pointers, full flags and stored sizes.
module eth_rx_slot_ctrl
  import eth_pkg::*;
#(
  parameter int slot_p   = 2,
  parameter int size_w_p = 12,
  localparam int ptr_w_lp = $clog2(slot_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                commit_i,
  input  logic [size_w_p-1:0] commit_size_i,
  input  logic                ack_i,
  output logic                free_o,
  output logic                avail_o,
  output logic [ptr_w_lp-1:0] head_o,
  output logic [ptr_w_lp-1:0] tail_o,
  output logic [size_w_p-1:0] head_size_o
);

  logic [slot_p-1:0]   full_q;
  logic [size_w_p-1:0] size_q [slot_p];
  logic [ptr_w_lp-1:0] head_q, tail_q;

  // Commit and ack touch different slots, so both may land in one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < slot_p; i++) size_q[i] <= '0;
    end else begin
      if (commit_i) begin
        full_q[tail_q] <= 1'b1;
        size_q[tail_q] <= commit_size_i;
        tail_q         <= tail_q + ptr_w_lp'(1);
      end
      if (ack_i) begin
        full_q[head_q] <= 1'b0;
        head_q         <= head_q + ptr_w_lp'(1);
      end
    end
  end

  assign free_o      = ~full_q[tail_q];
  assign avail_o     = full_q[head_q];
  assign head_o      = head_q;
  assign tail_o      = tail_q;
  assign head_size_o = size_q[head_q];

endmodule

// File: rtl/ethernet_receiver.sv
// RX path: AXI-Stream frames from the MAC into a slot_p-deep packet buffer read by the host.
// Define ETH_RX_DROP_COUNT_EN to build the dropped-frame counter; otherwise drop_count_o is 0.
module ethernet_receiver
  import eth_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int eth_mtu_p    = 2048,
  parameter int slot_p       = 2,
  parameter int recv_count_p = 65535,
  localparam int bytes_lp    = data_width_p / 8,
  localparam int lg_bytes_lp = $clog2(bytes_lp),
  localparam int addr_w_lp   = eth_addr_width(eth_mtu_p),
  localparam int size_w_lp   = eth_size_width(eth_mtu_p),
  localparam int rsz_w_lp    = $clog2(lg_bytes_lp + 1),
  localparam int cnt_w_lp    = $clog2(recv_count_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  ethernet_receiver_if.slave      rx_axis,
  output logic                    packet_avail_o,
  input  logic                    packet_ack_i,
  input  logic                    packet_rvalid_i,
  input  logic [addr_w_lp-1:0]    packet_raddr_i,
  input  logic [rsz_w_lp-1:0]     packet_rdata_size_i,
  output logic [data_width_p-1:0] packet_rdata_o,
  output logic [size_w_lp-1:0]    packet_rsize_o,
  output logic [cnt_w_lp-1:0]     recv_count_o,
  output logic [cnt_w_lp-1:0]     drop_count_o,
  output rx_state_e               rx_state_o
);

  localparam int words_lp  = eth_mtu_p / bytes_lp;
  localparam int ptr_w_lp  = $clog2(slot_p);
  localparam int word_w_lp = addr_w_lp - lg_bytes_lp;

  logic                    tready_q;
  rx_state_e               state_q, state_d;
  logic [size_w_lp-1:0]    byte_cnt_q, byte_cnt_d, base, sum;
  logic [3:0]              keep_cnt;
  logic                    beat, overflow, slot_free, avail;
  logic                    wr_en, commit, recv_inc, drop_inc;
  logic [ptr_w_lp-1:0]     head, tail;
  logic [size_w_lp-1:0]    head_size;
  logic [ptr_w_lp+word_w_lp-1:0] wr_idx, rd_idx;
  logic [data_width_p-1:0] mem_r [slot_p*words_lp];
  logic [data_width_p-1:0] rd_word, rd_shift, rd_next, rdata_q;
  logic [cnt_w_lp-1:0]     recv_cnt_q;

  eth_rx_slot_ctrl #(.slot_p(slot_p), .size_w_p(size_w_lp)) u_slot_ctrl (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .commit_i     (commit),
    .commit_size_i(sum),
    .ack_i        (packet_ack_i),
    .free_o       (slot_free),
    .avail_o      (avail),
    .head_o       (head),
    .tail_o       (tail),
    .head_size_o  (head_size)
  );

  // Never backpressure: ready rises on the first edge after reset and stays high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) tready_q <= 1'b0;
    else         tready_q <= 1'b1;
  end

  assign beat     = rx_axis.tvalid & tready_q;
  assign keep_cnt = keep_popcount(8'(rx_axis.tkeep));
  assign base     = (state_q == IDLE) ? '0 : byte_cnt_q;
  assign sum      = base + size_w_lp'(keep_cnt);
  assign overflow = sum > size_w_lp'(eth_mtu_p);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (beat) begin
      case (state_q)
        IDLE:    if (!rx_axis.tlast) state_d = slot_free ? RECV : DROP;
        RECV:    if (rx_axis.tlast) state_d = IDLE;
                 else if (overflow) state_d = DROP;
        DROP:    if (rx_axis.tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A first beat in IDLE follows the same store/commit/drop rules as RECV, with base 0.
  always_comb begin
    wr_en      = 1'b0;
    commit     = 1'b0;
    recv_inc   = 1'b0;
    drop_inc   = 1'b0;
    byte_cnt_d = byte_cnt_q;
    if (beat) begin
      case (state_q)
        IDLE, RECV: begin
          if ((state_q == IDLE && !slot_free) || overflow) begin
            drop_inc = rx_axis.tlast;
          end else begin
            wr_en      = 1'b1;
            byte_cnt_d = sum;
            if (rx_axis.tlast) begin
              if (rx_axis.tuser) begin
                drop_inc = 1'b1;
              end else begin
                commit   = 1'b1;
                recv_inc = 1'b1;
              end
            end
          end
        end
        DROP:    drop_inc = rx_axis.tlast;
        default: ;
      endcase
    end
  end

  assign wr_idx = {tail, base[addr_w_lp-1:lg_bytes_lp]};
  assign rd_idx = {head, packet_raddr_i[addr_w_lp-1:lg_bytes_lp]};

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < bytes_lp; b++)
        if (rx_axis.tkeep[b]) mem_r[wr_idx][b*8 +: 8] <= rx_axis.tdata[b*8 +: 8];
    end
  end

  assign rd_word  = mem_r[rd_idx];
  assign rd_shift = rd_word >> {packet_raddr_i[lg_bytes_lp-1:0], 3'b000};

  always_comb begin
    rd_next = '0;
    for (int b = 0; b < bytes_lp; b++)
      if ((b >> packet_rdata_size_i) == 0) rd_next[b*8 +: 8] = rd_shift[b*8 +: 8];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)              rdata_q <= '0;
    else if (packet_rvalid_i) rdata_q <= rd_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) recv_cnt_q <= '0;
    else if (recv_inc && recv_cnt_q != cnt_w_lp'(recv_count_p))
      recv_cnt_q <= recv_cnt_q + cnt_w_lp'(1);
  end

`ifdef ETH_RX_DROP_COUNT_EN
  logic [cnt_w_lp-1:0] drop_cnt_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) drop_cnt_q <= '0;
    else if (drop_inc && drop_cnt_q != cnt_w_lp'(recv_count_p))
      drop_cnt_q <= drop_cnt_q + cnt_w_lp'(1);
  end
  assign drop_count_o = drop_cnt_q;
`else
  logic unused_drop_inc;
  assign unused_drop_inc = drop_inc;
  assign drop_count_o    = '0;
`endif

  assign rx_axis.tready  = tready_q;
  assign packet_avail_o  = avail;
  assign packet_rsize_o  = avail ? head_size : '0;
  assign packet_rdata_o  = rdata_q;
  assign recv_count_o    = recv_cnt_q;
  assign rx_state_o      = state_q;

  a_ack_avail: assert property (@(posedge clk_i) disable iff (reset_i)
    packet_ack_i |-> avail);
  a_rd_avail: assert property (@(posedge clk_i) disable iff (reset_i)
    packet_rvalid_i |-> avail);
  a_rd_align: assert property (@(posedge clk_i) disable iff (reset_i)
    packet_rvalid_i |-> ((packet_raddr_i[lg_bytes_lp-1:0]
                          & lg_bytes_lp'((1 << packet_rdata_size_i) - 1)) == '0));
  a_keep: assert property (@(posedge clk_i) disable iff (reset_i)
    beat |-> (rx_axis.tlast
              ? (rx_axis.tkeep != '0 && (rx_axis.tkeep & (rx_axis.tkeep + bytes_lp'(1))) == '0)
              : (&rx_axis.tkeep)));
  a_width: assert property (@(posedge clk_i) disable iff (reset_i)
    (data_width_p == 32) || (data_width_p == 64));

endmodule

// File: tb/tb_ethernet_receiver.sv
// Directed bench for ethernet_receiver at 32-bit width with hand-computed expectations.
module tb_ethernet_receiver;
  import eth_pkg::*;

`ifdef ETH_RX_DROP_COUNT_EN
  localparam int drop_en_lp = 1;
`else
  localparam int drop_en_lp = 0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        packet_avail_o, packet_ack_i, packet_rvalid_i;
  logic [10:0] packet_raddr_i;
  logic [1:0]  packet_rdata_size_i;
  logic [31:0] packet_rdata_o;
  logic [11:0] packet_rsize_o;
  logic [16:0] recv_count_o, drop_count_o;
  rx_state_e   rx_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ethernet_receiver_if #(.data_width_p(32)) rx_axis ();

  ethernet_receiver dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .rx_axis            (rx_axis),
    .packet_avail_o     (packet_avail_o),
    .packet_ack_i       (packet_ack_i),
    .packet_rvalid_i    (packet_rvalid_i),
    .packet_raddr_i     (packet_raddr_i),
    .packet_rdata_size_i(packet_rdata_size_i),
    .packet_rdata_o     (packet_rdata_o),
    .packet_rsize_o     (packet_rsize_o),
    .recv_count_o       (recv_count_o),
    .drop_count_o       (drop_count_o),
    .rx_state_o         (rx_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_val(input int id, input int i);
    return 8'((i * 3 + id * 17) & 255);
  endfunction

  function automatic logic [31:0] exp_read(input int id, input int addr, input int sz);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < (1 << sz); k++) r[k*8 +: 8] = byte_val(id, addr + k);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the tlast beat has been taken.
  task automatic send_frame(input int id, input int len, input bit err, input bit ack_last);
    int nbeats;
    nbeats = (len + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < 4; k++) begin
        rx_axis.tdata[k*8 +: 8] = (b * 4 + k < len) ? byte_val(id, b * 4 + k) : 8'h00;
        rx_axis.tkeep[k]        = (b * 4 + k < len);
      end
      rx_axis.tvalid = 1'b1;
      rx_axis.tlast  = (b == nbeats - 1);
      rx_axis.tuser  = err && (b == nbeats - 1);
      packet_ack_i   = ack_last && (b == nbeats - 1);
      if (b == 0) check("tready_first_beat", 64'(rx_axis.tready), 64'(1));
      @(posedge clk_i); #1;
    end
    rx_axis.tvalid = 1'b0;
    rx_axis.tlast  = 1'b0;
    rx_axis.tuser  = 1'b0;
    packet_ack_i   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int id, input int addr, input int sz);
    packet_rvalid_i     = 1'b1;
    packet_raddr_i      = 11'(addr);
    packet_rdata_size_i = 2'(sz);
    exp_q.push_back(exp_read(id, addr, sz));
    @(posedge clk_i); #1;
    packet_rvalid_i = 1'b0;
    check(tag, 64'(packet_rdata_o), 64'(exp_q.pop_front()));
  endtask

  task automatic ack_head();
    packet_ack_i = 1'b1;
    @(posedge clk_i); #1;
    packet_ack_i = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int recv, input int drop);
    check({tag, "_recv"}, 64'(recv_count_o), 64'(recv));
    check({tag, "_drop"}, 64'(drop_count_o), 64'(drop * drop_en_lp));
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    reset_i = 1'b1;
    rx_axis.tdata = '0; rx_axis.tkeep = '0; rx_axis.tvalid = 1'b0;
    rx_axis.tlast = 1'b0; rx_axis.tuser = 1'b0;
    packet_ack_i = 1'b0; packet_rvalid_i = 1'b0;
    packet_raddr_i = '0; packet_rdata_size_i = '0;

    #12;
    check("rst_tready", 64'(rx_axis.tready), 64'(0));
    check("rst_avail", 64'(packet_avail_o), 64'(0));
    check("rst_rdata", 64'(packet_rdata_o), 64'(0));
    check("rst_rsize", 64'(packet_rsize_o), 64'(0));
    check_counts("rst", 0, 0);
    check("rst_state", 64'(rx_state_o), 64'(IDLE));
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("tready_after_rst", 64'(rx_axis.tready), 64'(1));

    // 64-byte frame
    send_frame(1, 64, 1'b0, 1'b0);
    check("f64_avail", 64'(packet_avail_o), 64'(1));
    check("f64_rsize", 64'(packet_rsize_o), 64'(64));
    check_counts("f64", 1, 0);
    read_chk("f64_word60", 1, 60, 2);
    read_chk("f64_byte0", 1, 0, 0);
    read_chk("f64_half2", 1, 2, 1);
    ack_head();
    check("f64_ack_avail", 64'(packet_avail_o), 64'(0));

    // 61-byte frame, partial last beat; then rdata must hold with rvalid low
    send_frame(2, 61, 1'b0, 1'b0);
    check("f61_rsize", 64'(packet_rsize_o), 64'(61));
    read_chk("f61_byte60", 2, 60, 0);
    @(posedge clk_i); #1;
    check("f61_rdata_hold", 64'(packet_rdata_o), 64'(exp_read(2, 60, 0)));
    ack_head();

    // Three back-to-back frames, no ack: third dropped
    send_frame(3, 20, 1'b0, 1'b0);
    send_frame(4, 24, 1'b0, 1'b0);
    send_frame(5, 16, 1'b0, 1'b0);
    check_counts("b2b", 4, 1);
    check("b2b_tready", 64'(rx_axis.tready), 64'(1));
    check("b2b_rsize_a", 64'(packet_rsize_o), 64'(20));
    read_chk("b2b_word16_a", 3, 16, 2);
    ack_head();
    check("b2b_avail_b", 64'(packet_avail_o), 64'(1));
    check("b2b_rsize_b", 64'(packet_rsize_o), 64'(24));
    read_chk("b2b_word20_b", 4, 20, 2);
    ack_head();
    check("b2b_empty", 64'(packet_avail_o), 64'(0));

    // Errored frame discarded, next good frame stored
    send_frame(6, 32, 1'b1, 1'b0);
    check("err_avail", 64'(packet_avail_o), 64'(0));
    check_counts("err", 4, 2);
    send_frame(7, 12, 1'b0, 1'b0);
    check("after_err_rsize", 64'(packet_rsize_o), 64'(12));
    read_chk("after_err_word8", 7, 8, 2);
    ack_head();

    // Oversize frame dropped, then a 100-byte and an exactly-MTU frame stored
    send_frame(8, 2052, 1'b0, 1'b0);
    check("big_avail", 64'(packet_avail_o), 64'(0));
    check("big_state", 64'(rx_state_o), 64'(IDLE));
    check_counts("big", 5, 3);
    send_frame(9, 100, 1'b0, 1'b0);
    check("f100_rsize", 64'(packet_rsize_o), 64'(100));
    read_chk("f100_word96", 9, 96, 2);
    ack_head();
    send_frame(10, 2048, 1'b0, 1'b0);
    check("mtu_rsize", 64'(packet_rsize_o), 64'(2048));
    read_chk("mtu_word2044", 10, 2044, 2);
    ack_head();
    check_counts("mtu", 7, 3);

    // Ack in the same cycle a frame commits into the last free slot
    send_frame(11, 8, 1'b0, 1'b0);
    check("sim_rsize_first", 64'(packet_rsize_o), 64'(8));
    send_frame(12, 16, 1'b0, 1'b1);
    check("sim_avail", 64'(packet_avail_o), 64'(1));
    check("sim_rsize_second", 64'(packet_rsize_o), 64'(16));
    check_counts("sim", 9, 3);
    read_chk("sim_word12", 12, 12, 2);
    ack_head();
    check("sim_empty", 64'(packet_avail_o), 64'(0));

    // Reset in the middle of a frame
    send_frame(13, 8, 1'b0, 1'b0);
    read_chk("pre_rst_word4", 13, 4, 2);
    for (int b = 0; b < 3; b++) begin
      rx_axis.tdata  = 32'hA5A5_0000 | 32'(b);
      rx_axis.tkeep  = 4'hF;
      rx_axis.tvalid = 1'b1;
      rx_axis.tlast  = 1'b0;
      @(posedge clk_i); #1;
    end
    check("mid_state", 64'(rx_state_o), 64'(RECV));
    reset_i        = 1'b1;
    rx_axis.tvalid = 1'b0;
    #1;
    check("mid_rst_tready", 64'(rx_axis.tready), 64'(0));
    check("mid_rst_avail", 64'(packet_avail_o), 64'(0));
    check("mid_rst_rdata", 64'(packet_rdata_o), 64'(0));
    check("mid_rst_rsize", 64'(packet_rsize_o), 64'(0));
    check_counts("mid_rst", 0, 0);
    check("mid_rst_state", 64'(rx_state_o), 64'(IDLE));
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    send_frame(14, 4, 1'b0, 1'b0);
    check("post_rst_avail", 64'(packet_avail_o), 64'(1));
    check("post_rst_rsize", 64'(packet_rsize_o), 64'(4));
    check_counts("post_rst", 1, 0);
    read_chk("post_rst_word0", 14, 0, 2);
    ack_head();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
